// File: rtl/signed_step_counter.sv
// Debounced three-button signed 4-bit up/down counter (-8..+7) feeding the 7-segment driver.
// Define SIGNED_STEP_SATURATE_EN to saturate at +7/-8 instead of wrapping (ovf pulses either way).
module signed_step_counter #(
    parameter int DB_CNT = 65000,
    parameter int DB_W   = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_up,
    input  logic       btn_dn,
    input  logic       btn_clr,
    output logic [3:0] data,
    output logic       ovf
);

    localparam int                BTN_N   = 3;
    localparam int                BTN_UP  = 0;
    localparam int                BTN_DN  = 1;
    localparam int                BTN_CLR = 2;
    localparam logic [DB_W-1:0]   DB_LAST = DB_W'(DB_CNT - 1);
    localparam logic [3:0]        MAX_POS = 4'b0111;
    localparam logic [3:0]        MIN_NEG = 4'b1000;

    logic [BTN_N-1:0] btn_raw_s;
    logic [BTN_N-1:0] sync1_r;
    logic [BTN_N-1:0] sync2_r;
    logic [BTN_N-1:0] stable_r;
    logic [BTN_N-1:0] stable_d_r;
    logic [BTN_N-1:0] press_r;
    logic [DB_W-1:0]  db_cnt_r [BTN_N];
    logic [3:0]       data_r;
    logic             ovf_r;

    assign btn_raw_s = {btn_clr, btn_dn, btn_up};

    // Per-button synchroniser, debounce filter and rising-edge press detector.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_r    <= {BTN_N{1'b0}};
            sync2_r    <= {BTN_N{1'b0}};
            stable_r   <= {BTN_N{1'b0}};
            stable_d_r <= {BTN_N{1'b0}};
            press_r    <= {BTN_N{1'b0}};
            for (int i = 0; i < BTN_N; i++) begin
                db_cnt_r[i] <= {DB_W{1'b0}};
            end
        end else begin
            sync1_r    <= btn_raw_s;
            sync2_r    <= sync1_r;
            stable_d_r <= stable_r;
            press_r    <= stable_r & ~stable_d_r;
            // A level is accepted only after DB_CNT consecutive disagreeing samples.
            for (int i = 0; i < BTN_N; i++) begin
                if (sync2_r[i] == stable_r[i]) begin
                    db_cnt_r[i] <= {DB_W{1'b0}};
                end else if (db_cnt_r[i] == DB_LAST) begin
                    stable_r[i] <= sync2_r[i];
                    db_cnt_r[i] <= {DB_W{1'b0}};
                end else begin
                    db_cnt_r[i] <= db_cnt_r[i] + DB_W'(1);
                end
            end
        end
    end

    // Counter update from press pulses: clear beats everything, up+dn cancels.
    always_ff @(posedge clk) begin
        if (rst) begin
            data_r <= 4'b0000;
            ovf_r  <= 1'b0;
        end else begin
            case ({press_r[BTN_CLR], press_r[BTN_UP], press_r[BTN_DN]})
                3'b100, 3'b101, 3'b110, 3'b111: begin
                    data_r <= 4'b0000;
                    ovf_r  <= 1'b0;
                end
                3'b011: begin
                    data_r <= data_r;
                    ovf_r  <= 1'b0;
                end
                3'b010: begin
                    if (data_r == MAX_POS) begin
`ifdef SIGNED_STEP_SATURATE_EN
                        data_r <= MAX_POS;
`else
                        data_r <= MIN_NEG;
`endif
                        ovf_r  <= 1'b1;
                    end else begin
                        data_r <= data_r + 4'd1;
                        ovf_r  <= 1'b0;
                    end
                end
                3'b001: begin
                    if (data_r == MIN_NEG) begin
`ifdef SIGNED_STEP_SATURATE_EN
                        data_r <= MIN_NEG;
`else
                        data_r <= MAX_POS;
`endif
                        ovf_r  <= 1'b1;
                    end else begin
                        data_r <= data_r - 4'd1;
                        ovf_r  <= 1'b0;
                    end
                end
                default: begin
                    data_r <= data_r;
                    ovf_r  <= 1'b0;
                end
            endcase
        end
    end

    assign data = data_r;
    assign ovf  = ovf_r;

endmodule
